// File: rtl/memwb_stage.sv
// MEM/WB pipeline register: write-back select, branch/jump resolution into a
// registered fetch redirect, and a squash state machine that kills younger bundles.
module memwb_stage #(
  parameter int SQUASH_DEPTH = 3,
  parameter int DW           = 32,
  parameter int RW           = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          stall,
  input  logic          RegWrt_In,
  input  logic          MemtoReg_In,
  input  logic          PCtoReg_In,
  input  logic          BrNeg_In,
  input  logic          BrZ_In,
  input  logic          Jump_In,
  input  logic          JumpMem_In,
  input  logic          Zero_In,
  input  logic          Neg_In,
  input  logic [DW-1:0] ALU_In,
  input  logic [DW-1:0] Data_In,
  input  logic [DW-1:0] PC_In,
  input  logic [DW-1:0] Branch_In,
  input  logic [RW-1:0] RD_In,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          pc_redirect,
  output logic [DW-1:0] pc_target,
  output logic          squashing,
  output logic [31:0]   retire_count
);

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  localparam logic [2:0] DEPTH = 3'(SQUASH_DEPTH);

  state_t        state_r, nextState_s;
  logic [2:0]    squashCnt_r, nextSquashCnt_s;
  logic          accept_s, live_s, taken_s;
  logic [DW-1:0] wbSel_s;

  logic          wbValidNext_s, wbWeNext_s, pcRedirectNext_s;
  logic [RW-1:0] wbRdNext_s;
  logic [DW-1:0] wbDataNext_s, pcTargetNext_s;
  logic [31:0]   retireNext_s;

  assign accept_s = in_valid & ~stall;
  assign live_s   = accept_s & (state_r == RUN);
  assign taken_s  = live_s & (Jump_In | JumpMem_In | (BrZ_In & Zero_In) | (BrNeg_In & Neg_In));

  // State and squash counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      squashCnt_r <= 3'd0;
    end else begin
      state_r     <= nextState_s;
      squashCnt_r <= nextSquashCnt_s;
    end
  end

  // Next-state logic: only accepted bundles advance the squash count
  always_comb begin
    nextState_s     = state_r;
    nextSquashCnt_s = squashCnt_r;
    case (state_r)
      RUN: begin
        if (taken_s) begin
          nextState_s     = SQUASH;
          nextSquashCnt_s = DEPTH;
        end else begin
          nextState_s     = RUN;
        end
      end
      SQUASH: begin
        if (accept_s) begin
          nextSquashCnt_s = squashCnt_r - 3'd1;
          if (squashCnt_r == 3'd1) begin
            nextState_s = RUN;
          end else begin
            nextState_s = SQUASH;
          end
        end else begin
          nextState_s = SQUASH;
        end
      end
      default: begin
        nextState_s     = RUN;
        nextSquashCnt_s = 3'd0;
      end
    endcase
  end

  // Write-back source priority: memory data, then return PC, then ALU
  always_comb begin
    if (MemtoReg_In) begin
      wbSel_s = Data_In;
    end else if (PCtoReg_In) begin
      wbSel_s = PC_In + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      wbSel_s = ALU_In;
    end
  end

  // Output next-values; data fields hold unless a live bundle arrives
  always_comb begin
    wbValidNext_s    = live_s;
    wbWeNext_s       = live_s & RegWrt_In & (RD_In != {RW{1'b0}});
    pcRedirectNext_s = taken_s;
    retireNext_s     = retire_count;
    wbRdNext_s       = wb_rd;
    wbDataNext_s     = wb_data;
    pcTargetNext_s   = pc_target;
    if (live_s) begin
      wbRdNext_s   = RD_In;
      wbDataNext_s = wbSel_s;
      retireNext_s = retire_count + 32'd1;
    end else begin
      retireNext_s = retire_count;
    end
    if (taken_s) begin
      pcTargetNext_s = JumpMem_In ? Data_In : Branch_In;
    end else begin
      pcTargetNext_s = pc_target;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= {RW{1'b0}};
      wb_data      <= {DW{1'b0}};
      pc_redirect  <= 1'b0;
      pc_target    <= {DW{1'b0}};
      retire_count <= 32'd0;
    end else begin
      wb_valid     <= wbValidNext_s;
      wb_we        <= wbWeNext_s;
      wb_rd        <= wbRdNext_s;
      wb_data      <= wbDataNext_s;
      pc_redirect  <= pcRedirectNext_s;
      pc_target    <= pcTargetNext_s;
      retire_count <= retireNext_s;
    end
  end

  assign squashing = (state_r == SQUASH);

endmodule

// File: doc/memwb_stage.md
Name: memwb_stage

Overview:
- Consumer end of the EX/MEM buffer.
- Registers each EX/MEM bundle into the MEM/WB pipeline register and selects the write-back value (ALU, data memory, or return PC).
- Resolves branches and jumps into a registered PC redirect, then squashes the younger instructions already in flight.
- Drives the register-file write port and the fetch-stage redirect.

Parameters:
SQUASH_DEPTH, 3, number of accepted instructions killed after a taken redirect (1..7)
DW, 32, datapath width of ALU/data/PC/target values
RW, 6, register-specifier width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  EX/MEM bundle holds a real instruction
stall  input  1  hold request from hazard unit; bundle not accepted this cycle
RegWrt_In  input  1  instruction writes register file
MemtoReg_In  input  1  write-back source = Data_In
PCtoReg_In  input  1  write-back source = PC_In+1
BrNeg_In  input  1  branch if Neg_In
BrZ_In  input  1  branch if Zero_In
Jump_In  input  1  unconditional jump to Branch_In
JumpMem_In  input  1  unconditional jump to Data_In
Zero_In  input  1  ALU zero flag
Neg_In  input  1  ALU negative flag
ALU_In  input  DW  ALU result
Data_In  input  DW  data-memory read value
PC_In  input  DW  PC of the instruction
Branch_In  input  DW  branch/jump target
RD_In  input  RW  destination register
wb_valid  output  1  MEM/WB register holds a live instruction
wb_we  output  1  register-file write strobe
wb_rd  output  RW  write address
wb_data  output  DW  write data
pc_redirect  output  1  one-cycle pulse: fetch must load pc_target
pc_target  output  DW  redirect address
squashing  output  1  squash state machine active
retire_count  output  32  live instructions retired, wraps at 2^32

Behaviour:
- Reset (async, rst=1): all outputs 0, state RUN, squash counter 0. Reset mid-squash abandons the squash.
- accept = in_valid & ~stall.
- live = accept & (state==RUN).
- taken = live & (Jump_In | JumpMem_In | (BrZ_In & Zero_In) | (BrNeg_In & Neg_In)).
- Write-back select, priority order:
  - MemtoReg_In → Data_In.
  - else PCtoReg_In → PC_In+1, modulo 2^DW.
  - else ALU_In.
- Latency: one cycle. Outputs for a bundle appear on the edge after acceptance.
- On each edge:
  - wb_valid ← live.
  - wb_we ← live & RegWrt_In & (RD_In != 0). Register 0 is never written.
  - wb_rd and wb_data load only when live; otherwise they hold their old values.
- stall=1 inserts a bubble: wb_valid=0, wb_we=0 next cycle, data outputs hold, squash counter holds.
- Redirect:
  - pc_redirect ← taken.
  - pc_target ← JumpMem_In ? Data_In : Branch_In, loaded only when taken.
  - pc_redirect is high for exactly one cycle per taken instruction.
- Jump/branch with RegWrt_In (link) both writes back and redirects in the same cycle.
- State machine:
  - RUN: taken → SQUASH, counter ← SQUASH_DEPTH.
  - SQUASH: each accept kills the bundle (no write-back, no redirect, not retired) and decrements the counter. Counter reaching 0 → RUN.
  - Stalled or invalid cycles do not decrement.
  - The first bundle accepted after returning to RUN is live.
  - squashing = (state==SQUASH).
- retire_count increments by 1 on every edge where live. It wraps from 0xFFFFFFFF to 0.
- Simultaneous stall and in_valid: stall wins, bundle not consumed.
- A taken condition on a squashed bundle is ignored.

Test Plan:
- ALU op: accept RegWrt=1, RD=5, ALU_In=0x1234, MemtoReg=PCtoReg=0 → next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234, retire_count=1.
- Load and link: MemtoReg=1, Data_In=0xDEAD → wb_data=0xDEAD. PCtoReg=1, PC_In=0xFFFFFFFF → wb_data=0. RD=0 → wb_we=0, wb_valid=1.
- BrZ taken, Zero=1, Branch_In=0x40 → pc_redirect one-cycle pulse, pc_target=0x40. Next 3 accepted bundles give wb_valid=0. Fourth gives wb_valid=1. BrNeg with Neg=0 → no redirect.
- Squash with stalls: taken, then alternate stall=1/0 with in_valid=1 → squashing stays 1 until 3 non-stalled accepts. Each stall cycle gives wb_we=0 with wb_data held.
- JumpMem, Data_In=0x80, RegWrt=1, PCtoReg=1 → pc_target=0x80. Same-cycle wb_data=PC_In+1 and wb_we=1.
- Async reset mid-squash: assert rst between edges → outputs 0 immediately, squashing=0, retire_count=0. First accept after release is live.
